// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: state encodings,
// the hard-wired zero register, counter widths and a saturating increment.
package hazard_ctrl_pkg;

  localparam logic [2:0] ST_BOOT  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_STALL = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int SEQ_CNT_W  = 4;
  localparam int PERF_CNT_W = 32;

  localparam logic [PERF_CNT_W-1:0] PERF_CNT_MAX = '1;

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] val);
    return (val == PERF_CNT_MAX) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: the instruction in ID reads a register that a
// load currently in EX will write. x0 never causes a hazard; matching on
// both source registers still yields a single flag.
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       hazard
);

  logic rs1_match;
  logic rs2_match;

  // Pure combinational compare, no state.
  always_comb begin
    rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
    hazard    = ex_mem_read && (ex_rd != REG_X0) && (rs1_match || rs2_match);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: boot, load-use stalls,
// taken-branch redirect/flush and halt drain.
// Optional bubble/flush performance counters are built when the macro
// HAZARD_PERF_CNT_EN is defined; otherwise StallCnt/FlushCnt read 0.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// BOOT     | pipeline held and flushed; PC loaded with RESET_PC on last cycle
// RUN      | normal flow; branch redirect, first load-use bubble, halt entry
// STALL    | additional load-use bubbles (LOAD_STALL > 1)
// DRAIN    | fetch stopped, older instructions retire
// HALT     | core stopped until Reset
module pipeline_hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              BOOT_CYCLES  = 2,
  parameter int              LOAD_STALL   = 1,
  parameter int              DRAIN_CYCLES = 3
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [4:0]      IdRs1,
  input  logic [4:0]      IdRs2,
  input  logic            IdUsesRs1,
  input  logic            IdUsesRs2,
  input  logic            IdHalt,
  input  logic [4:0]      ExRd,
  input  logic            ExMemRead,
  input  logic            BrTaken,
  input  logic [XLEN-1:0] BrTarget,
  output logic            PCWrite,
  output logic            IFIDWrite,
  output logic            IFIDFlush,
  output logic            IDEXFlush,
  output logic            Jump,
  output logic [XLEN-1:0] NewPC,
  output logic            Halted,
  output logic [31:0]     StallCnt,
  output logic [31:0]     FlushCnt
);

  localparam logic [SEQ_CNT_W-1:0] BOOT_LAST  = SEQ_CNT_W'(BOOT_CYCLES - 1);
  localparam logic [SEQ_CNT_W-1:0] STALL_LAST = SEQ_CNT_W'(LOAD_STALL - 1);
  localparam logic [SEQ_CNT_W-1:0] DRAIN_LAST = SEQ_CNT_W'(DRAIN_CYCLES - 1);
  localparam bit                   MULTI_STALL = (LOAD_STALL > 1);

  logic [2:0]           state, state_nxt;
  logic [SEQ_CNT_W-1:0] cnt, cnt_nxt;
  logic                 load_use;

  load_use_detect u_load_use_detect (
    .id_rs1      (IdRs1),
    .id_rs2      (IdRs2),
    .id_uses_rs1 (IdUsesRs1),
    .id_uses_rs2 (IdUsesRs2),
    .ex_rd       (ExRd),
    .ex_mem_read (ExMemRead),
    .hazard      (load_use)
  );

  // State and sequence counter; Reset wins over everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_BOOT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Zero-latency pipeline controls and next-state selection.
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    Jump      = 1'b0;
    NewPC     = '0;
    Halted    = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;

    case (state)
      ST_BOOT: begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
        cnt_nxt   = cnt + 1'b1;
        if (cnt == BOOT_LAST) begin
          PCWrite   = 1'b1;
          Jump      = 1'b1;
          NewPC     = RESET_PC;
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      end

      ST_RUN: begin
        if (BrTaken) begin
          // Redirect squashes whatever sits in IF/ID, including hazards/halts.
          Jump      = 1'b1;
          NewPC     = BrTarget;
          IFIDFlush = 1'b1;
          IDEXFlush = 1'b1;
        end else if (load_use) begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          IDEXFlush = 1'b1;
          if (MULTI_STALL) begin
            state_nxt = ST_STALL;
            cnt_nxt   = SEQ_CNT_W'(1);
          end
        end else if (IdHalt) begin
          // Halt instruction moves on to EX; nothing behind it is fetched.
          PCWrite   = 1'b0;
          IFIDFlush = 1'b1;
          state_nxt = ST_DRAIN;
          cnt_nxt   = '0;
        end
      end

      ST_STALL: begin
        if (BrTaken) begin
          Jump      = 1'b1;
          NewPC     = BrTarget;
          IFIDFlush = 1'b1;
          IDEXFlush = 1'b1;
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          IDEXFlush = 1'b1;
          cnt_nxt   = cnt + 1'b1;
          if (cnt == STALL_LAST) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end
        end
      end

      ST_DRAIN: begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IFIDFlush = 1'b1;
        cnt_nxt   = cnt + 1'b1;
        if (cnt == DRAIN_LAST) begin
          state_nxt = ST_HALT;
          cnt_nxt   = '0;
        end
      end

      ST_HALT: begin
        Halted    = 1'b1;
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
      end

      default: begin
        // Unreachable encodings recover through BOOT.
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
        state_nxt = ST_BOOT;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic                  stall_ev;
  logic                  flush_ev;
  logic [PERF_CNT_W-1:0] stall_cnt_q;
  logic [PERF_CNT_W-1:0] flush_cnt_q;

  // Bubble and redirect events; none occur in HALT, so the counters freeze there.
  always_comb begin
    stall_ev = !BrTaken && (((state == ST_RUN) && load_use) || (state == ST_STALL));
    flush_ev = BrTaken && ((state == ST_RUN) || (state == ST_STALL));
  end

  // Saturating event counters, cleared by Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_ev) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_ev) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (LOAD_STALL = 1, 3, 2) share
// one stimulus stream; directed scenarios plus a randomized run against a
// cycle-level model of the controller's rules.
module tb_pipeline_hazard_ctrl;

  localparam int N = 3;

  typedef struct packed {
    logic        pcw;
    logic        ifidw;
    logic        ifidf;
    logic        idexf;
    logic        jmp;
    logic        hlt;
    logic [63:0] npc;
  } outs_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  IdRs1, IdRs2, ExRd;
  logic        IdUsesRs1, IdUsesRs2, IdHalt, ExMemRead, BrTaken;
  logic [63:0] BrTarget;

  logic        pcw[N], ifidw[N], ifidf[N], idexf[N], jmp[N], hlt[N];
  logic [63:0] npc[N];
  logic [31:0] scnt[N], fcnt[N];

  int compared   = 0;
  int mismatched = 0;

  // Model: cycles still to spend in each phase, plus event tallies.
  int          boot_left[N];
  int          extra[N];
  int          drain_left[N];
  bit          m_halt[N];
  int unsigned m_scnt[N];
  int unsigned m_fcnt[N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    pipeline_hazard_ctrl #(
      .XLEN(64), .RESET_PC(64'h0), .BOOT_CYCLES(2),
      .LOAD_STALL(g == 0 ? 1 : (g == 1 ? 3 : 2)), .DRAIN_CYCLES(3)
    ) u_dut (
      .Clk(Clk), .Reset(Reset), .IdRs1(IdRs1), .IdRs2(IdRs2),
      .IdUsesRs1(IdUsesRs1), .IdUsesRs2(IdUsesRs2), .IdHalt(IdHalt),
      .ExRd(ExRd), .ExMemRead(ExMemRead), .BrTaken(BrTaken), .BrTarget(BrTarget),
      .PCWrite(pcw[g]), .IFIDWrite(ifidw[g]), .IFIDFlush(ifidf[g]), .IDEXFlush(idexf[g]),
      .Jump(jmp[g]), .NewPC(npc[g]), .Halted(hlt[g]),
      .StallCnt(scnt[g]), .FlushCnt(fcnt[g])
    );
  end

  always #5 Clk = ~Clk;

  function automatic int ls_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
  endfunction

  function automatic bit lu();
    return ExMemRead && (ExRd != 5'd0) &&
           ((IdUsesRs1 && IdRs1 == ExRd) || (IdUsesRs2 && IdRs2 == ExRd));
  endfunction

  function automatic outs_t got_of(input int i);
    return '{pcw[i], ifidw[i], ifidf[i], idexf[i], jmp[i], hlt[i], npc[i]};
  endfunction

  function automatic outs_t model_out(input int i);
    outs_t o;
    o = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    if (m_halt[i]) begin
      o = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0};
    end else if (boot_left[i] > 0) begin
      o = '{(boot_left[i] == 1), 1'b0, 1'b1, 1'b1, (boot_left[i] == 1), 1'b0, 64'h0};
    end else if (drain_left[i] > 0) begin
      o = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
    end else if (BrTaken) begin
      o = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, BrTarget};
    end else if (extra[i] > 0 || lu()) begin
      o = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
    end else if (IdHalt) begin
      o = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
    end
    return o;
  endfunction

  task automatic model_advance();
    for (int i = 0; i < N; i++) begin
      if (Reset) begin
        boot_left[i] = 2; extra[i] = 0; drain_left[i] = 0;
        m_halt[i] = 1'b0; m_scnt[i] = 0; m_fcnt[i] = 0;
      end else if (m_halt[i]) begin
      end else if (boot_left[i] > 0) begin
        boot_left[i]--;
      end else if (drain_left[i] > 0) begin
        drain_left[i]--;
        if (drain_left[i] == 0) m_halt[i] = 1'b1;
      end else if (BrTaken) begin
        extra[i] = 0; m_fcnt[i]++;
      end else if (extra[i] > 0) begin
        extra[i]--; m_scnt[i]++;
      end else if (lu()) begin
        extra[i] = ls_of(i) - 1; m_scnt[i]++;
      end else if (IdHalt) begin
        drain_left[i] = 3;
      end
    end
  endtask

  task automatic step();
    model_advance();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    IdRs1 = 0; IdRs2 = 0; ExRd = 0; IdUsesRs1 = 0; IdUsesRs2 = 0;
    IdHalt = 0; ExMemRead = 0; BrTaken = 0; BrTarget = 64'h0;
  endtask

  task automatic set_hazard(input logic [4:0] rd);
    ExMemRead = 1; ExRd = rd; IdRs2 = 5'd5; IdUsesRs2 = 1; IdRs1 = 5'd7; IdUsesRs1 = 1;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    outs_t e, g;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      #2;
      if (c == 0)      e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0};
      else if (c == 1) e = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0};
      else             e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
      for (int i = 0; i < N; i++) begin
        g = got_of(i);
        compared++;
        if (g !== e) begin
          mismatched++;
          $display("FAIL boot_c%0d inst%0d got=%h exp=%h", c, i, g, e);
        end
      end
      step();
    end
  endtask

  task automatic test_load_use();
    outs_t e, g;
    bit s;
    set_hazard(5'd5);
    for (int j = 0; j < 4; j++) begin
      #2;
      for (int i = 0; i < N; i++) begin
        s = (j < ls_of(i));
        e = '{!s, !s, 1'b0, s, 1'b0, 1'b0, 64'h0};
        g = got_of(i);
        compared++;
        if (g !== e) begin
          mismatched++;
          $display("FAIL load_use_j%0d inst%0d got=%h exp=%h", j, i, g, e);
        end
      end
      step();
      idle();
    end
    set_hazard(5'd0);
    IdRs2 = 5'd0;
    #2;
    e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    for (int i = 0; i < N; i++) begin
      g = got_of(i);
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL x0_no_stall inst%0d got=%h exp=%h", i, g, e);
      end
    end
    step();
    idle();
  endtask

  task automatic test_branch();
    outs_t e, g;
    set_hazard(5'd5);
    BrTaken = 1; BrTarget = 64'h40;
    #2;
    e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h40};
    for (int i = 0; i < N; i++) begin
      g = got_of(i);
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL br_over_lu inst%0d got=%h exp=%h", i, g, e);
      end
    end
    step();
    idle();
    #2;
    e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    for (int i = 0; i < N; i++) begin
      g = got_of(i);
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL br_no_stall inst%0d got=%h exp=%h", i, g, e);
      end
    end
    // Branch arriving while the multi-cycle instances are mid-stall.
    set_hazard(5'd5);
    step();
    idle();
    BrTaken = 1; BrTarget = 64'h44;
    #2;
    e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h44};
    for (int i = 0; i < N; i++) begin
      g = got_of(i);
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL br_in_stall inst%0d got=%h exp=%h", i, g, e);
      end
    end
    step();
    idle();
    #2;
    e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    for (int i = 0; i < N; i++) begin
      g = got_of(i);
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL after_br_stall inst%0d got=%h exp=%h", i, g, e);
      end
    end
  endtask

  task automatic test_halt_drain();
    outs_t e, g;
    IdHalt = 1;
    for (int j = 0; j < 7; j++) begin
      if (j == 2) begin
        BrTaken = 1; BrTarget = 64'h80;
      end
      #2;
      if (j == 0)     e = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
      else if (j < 4) e = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
      else            e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0};
      for (int i = 0; i < N; i++) begin
        g = got_of(i);
        compared++;
        if (g !== e) begin
          mismatched++;
          $display("FAIL halt_drain_j%0d inst%0d got=%h exp=%h", j, i, g, e);
        end
      end
      step();
      idle();
    end
  endtask

  task automatic test_reset_mid();
    outs_t e, g;
    e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      step();
      step();
      if (k == 0) begin
        set_hazard(5'd5);
        step();
        idle();
      end else begin
        IdHalt = 1;
        step();
        idle();
        for (int j = 0; j < 4; j++) step();
      end
      Reset = 1;
      step();
      Reset = 0;
      #2;
      for (int i = 0; i < N; i++) begin
        g = got_of(i);
        compared++;
        if (g !== e || scnt[i] !== 32'd0 || fcnt[i] !== 32'd0) begin
          mismatched++;
          $display("FAIL reset_mid_k%0d inst%0d got=%h cnt=%0d/%0d exp=%h cnt=0/0",
                   k, i, g, scnt[i], fcnt[i], e);
        end
      end
    end
  endtask

  task automatic test_perf();
    logic [31:0] es, ef;
    do_reset();
    step();
    step();
    for (int h = 0; h < 2; h++) begin
      set_hazard(5'd5);
      step();
      idle();
      for (int j = 0; j < 3; j++) step();
    end
    for (int b = 0; b < 3; b++) begin
      BrTaken = 1; BrTarget = 64'h100 + 64'(b);
      step();
      idle();
      step();
    end
    #2;
    for (int i = 0; i < N; i++) begin
`ifdef HAZARD_PERF_CNT_EN
      es = 32'(2 * ls_of(i));
      ef = 32'd3;
`else
      es = 32'd0;
      ef = 32'd0;
`endif
      compared++;
      if (scnt[i] !== es || fcnt[i] !== ef) begin
        mismatched++;
        $display("FAIL perf inst%0d got=%0d/%0d exp=%0d/%0d", i, scnt[i], fcnt[i], es, ef);
      end
    end
  endtask

  task automatic test_random();
    outs_t e, g;
    logic [31:0] es, ef;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      Reset     = ($urandom_range(0, 99) < 3);
      IdRs1     = 5'($urandom_range(0, 3));
      IdRs2     = 5'($urandom_range(0, 3));
      ExRd      = 5'($urandom_range(0, 3));
      IdUsesRs1 = 1'($urandom_range(0, 1));
      IdUsesRs2 = 1'($urandom_range(0, 1));
      ExMemRead = 1'($urandom_range(0, 1));
      BrTaken   = ($urandom_range(0, 99) < 15);
      IdHalt    = ($urandom_range(0, 99) < 3);
      BrTarget  = {$urandom, $urandom};
      #2;
      for (int i = 0; i < N; i++) begin
        e = model_out(i);
        g = got_of(i);
`ifdef HAZARD_PERF_CNT_EN
        es = m_scnt[i];
        ef = m_fcnt[i];
`else
        es = 32'd0;
        ef = 32'd0;
`endif
        compared++;
        if (g !== e || scnt[i] !== es || fcnt[i] !== ef) begin
          mismatched++;
          $display("FAIL random_c%0d inst%0d got=%h cnt=%0d/%0d exp=%h cnt=%0d/%0d",
                   c, i, g, scnt[i], fcnt[i], e, es, ef);
        end
      end
      step();
    end
    Reset = 0;
    idle();
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_halt_drain();
    test_reset_mid();
    test_perf();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
